ex_muldiv_seq: RTL
==================

// Module: ex_muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer attached beside the EX-stage ALU.
//  - Accepts one M-extension op from EX and computes it over XLEN+2 cycles.
//  - Stalls IF/ID/EX while it works, then delivers the result for one cycle
//    so the pipeline advances with the result into EX/MEM.
//  - Operands arrive already forwarded (post forwarding-mux rs1/rs2).
// PARAMETERS
//  XLEN      32   operand/result width
//  CNT_W     6    iteration counter width, >= $clog2(XLEN)+1
// PORTS
//  clk       in   1     single clock, all state on rising edge
//  rst       in   1     synchronous, active-low reset
//  start_i   in   1     EX holds a valid M-op (opcode 0110011, funct7 0000001)
//  flush_i   in   1     EX instruction killed (branch/jump taken); beats start_i
//  op_i      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1_i     in   XLEN  forwarded rs1 operand
//  rs2_i     in   XLEN  forwarded rs2 operand
//  rd_i      in   5     destination register of the op
//  stall_o   out  1     hold IF/ID/EX registers and PC
//  busy_o    out  1     state != IDLE
//  done_o    out  1     one-cycle pulse, result_o/rd_o valid
//  result_o  out  XLEN  registered result, held until next accepted start
//  rd_o      out  5     registered rd of completed op
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE, counter 0, done_o 0, result_o 0, rd_o 0,
//    busy_o 0; any op in flight is abandoned, no done_o.
//  - FSM: IDLE -> CALC (start_i & ~flush_i, normal op)
//         IDLE -> DONE (start_i & ~flush_i, div-by-zero or DIV overflow)
//         CALC -> CALC while counter < XLEN-1; CALC -> FIX at counter == XLEN-1
//         FIX -> DONE; DONE -> IDLE unconditionally
//         any state -> IDLE on flush_i (no done_o, result_o unchanged)
//  - Accept (IDLE): latch op, rd, |rs1|,|rs2| (abs only for signed operand kinds),
//    result sign: MUL*/DIV = s1^s2, REM = s1; counter cleared.
//  - CALC: MUL family: one shift-add step per cycle into 2*XLEN product.
//    DIV family: one restoring step per cycle (shift remainder, trial subtract,
//    set quotient bit). counter increments each CALC cycle.
//  - FIX: conditional two's-complement negate; select MUL low word, MULH* high
//    word, quotient or remainder; register into result_o/rd_o.
//  - DONE: done_o=1, stall_o=0; start_i ignored (same instruction still in EX);
//    next instruction first sampled in IDLE on the following cycle.
//  - stall_o = (IDLE & start_i & ~flush_i) | CALC | FIX  (combinational).
//  - start_i while CALC/FIX is ignored (EX is frozen, op unchanged).
//  - Latency, start sampled in cycle 0: normal ops stall cycles 0..XLEN+1,
//    done_o in cycle XLEN+2 (34 at XLEN=32); fast path done_o in cycle 1.
//  - Div by zero: quotient all-ones, remainder = rs1. DIV/REM with
//    rs1=0x8000_0000, rs2=-1: quotient 0x8000_0000, remainder 0.
//  - All arithmetic unsigned on magnitudes; product 2*XLEN, remainder XLEN+1.
// STRUCTURE
//  - Package ex_md_pkg: md_op_e (8 funct3 codes), md_state_e {IDLE,CALC,FIX,
//    DONE}, OPC_OP=7'b0110011, F7_MULDIV=7'b0000001, is_div()/is_signed() fns.
//  - Sub-module ex_md_step: combinational single-iteration shift-add / restoring
//    step; sequencer owns FSM, counter, sign handling and result registers.
// TESTING
//  - MUL 7 x -3 -> result_o 0xFFFF_FFEB, stall_o high cycles 0..33, done_o cycle 34.
//  - MULH 0x8000_0000^2 -> 0x4000_0000; MULHU 0xFFFF_FFFF^2 -> 0xFFFF_FFFE;
//    MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF.
//  - DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU -> 2.
//  - DIVU 5/0 -> 0xFFFF_FFFF, REM 5/0 -> 5, DIV 0x8000_0000/-1 -> 0x8000_0000;
//    all with done_o in cycle 1, one stall cycle.
//  - flush_i in cycle 10 of DIV -> IDLE next cycle, stall_o 0, no done_o,
//    result_o unchanged; following MUL 6x7 -> 42 at cycle 34 of its own start.
//  - rst low in cycle 5 of MUL -> all outputs 0 next cycle; back-to-back MUL
//    ops (second start in cycle after DONE) both complete, rd_o matches each.

Source files
------------

// File: rtl/ex_md_pkg.sv
// ---------------------------------------------------------------------------
// ex_md_pkg
//   Shared definitions for the EX-stage RV32M multiply/divide sequencer:
//   funct3 operation codes, sequencer state encoding, the R-type opcode and
//   funct7 that identify an M-extension op, and small decode helpers.
//   No ports (package).
// ---------------------------------------------------------------------------
package ex_md_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // funct3[2] splits the multiply family from the divide family.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Remainder ops take their result sign from the dividend only.
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // Whether an operand is interpreted as two's complement.
  // rs2_sel = 0 asks about rs1, rs2_sel = 1 asks about rs2.
  function automatic logic is_signed(input logic [2:0] op, input logic rs2_sel);
    logic s;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
      OP_MULHSU:                       s = ~rs2_sel;
      default:                         s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ex_md_step.sv
// ---------------------------------------------------------------------------
// ex_md_step
//   One combinational iteration of the sequencer datapath.
//   Multiply: shift-add on the product {hi, lo}; lo starts as the multiplier,
//             opnd is the multiplicand.
//   Divide:   restoring step; hi is the partial remainder, lo shifts the
//             dividend out at the top and the quotient bits in at the bottom,
//             opnd is the divisor.
// Ports
//   div_i   1     select divide step (else multiply step)
//   hi_i    XLEN  upper product half / partial remainder
//   lo_i    XLEN  lower product half / dividend-quotient shifter
//   opnd_i  XLEN  multiplicand / divisor magnitude
//   hi_o    XLEN  next hi
//   lo_o    XLEN  next lo
// ---------------------------------------------------------------------------
module ex_md_step
  import ex_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    // Multiply: add multiplicand into the top half when the current
    // multiplier bit is set, then shift the whole product right by one.
    sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);

    // Divide: the shifted remainder needs one extra bit; the difference is
    // only kept when it is non-negative, and then it fits in XLEN bits.
    shifted = {hi_i, lo_i[XLEN-1]};
    ge      = (shifted >= {1'b0, opnd_i});
    diff    = shifted[XLEN-1:0] - opnd_i;

    if (div_i) begin
      hi_o = ge ? diff : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// ---------------------------------------------------------------------------
// ex_muldiv_seq
//   Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
//   Works on operand magnitudes for XLEN iterations, fixes the sign, then
//   presents the result with a one-cycle done pulse.
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous active-low reset
//   start_i    in   1     EX holds a valid M-op
//   flush_i    in   1     EX instruction killed; overrides start_i
//   op_i       in   3     funct3 of the M-op
//   rs1_i      in   XLEN  forwarded rs1
//   rs2_i      in   XLEN  forwarded rs2
//   rd_i       in   5     destination register
//   stall_o    out  1     freeze IF/ID/EX and PC
//   busy_o     out  1     sequencer not idle
//   done_o     out  1     one-cycle pulse, result_o/rd_o valid
//   result_o   out  XLEN  registered result
//   rd_o       out  5     registered rd of completed op
//   state_o    out  2     current sequencer state (debug)
// Handshake: start_i is a request that is taken only in IDLE when flush_i is
//   low; stall_o acts as the inverse of ready, holding EX (and therefore
//   start_i and the operands) steady until the cycle done_o is high, in which
//   stall_o is low and the pipeline advances with result_o.
// ---------------------------------------------------------------------------
module ex_muldiv_seq
  import ex_md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic [1:0]      state_o
);

  localparam logic [1:0]       S_IDLE   = IDLE;
  localparam logic [1:0]       S_CALC   = CALC;
  localparam logic [1:0]       S_FIX    = FIX;
  localparam logic [1:0]       S_DONE   = DONE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_pend_q, rd_pend_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [4:0]       rd_q, rd_d;

  logic             accept;
  logic             s1, s2;
  logic [XLEN-1:0]  abs1, abs2;
  logic             div_zero, div_ovf;
  logic [XLEN-1:0]  fast_res;
  logic [XLEN-1:0]  step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]  quo_s, rem_s, fix_res;

  ex_md_step #(.XLEN(XLEN)) u_step (
    .div_i  (is_div(op_q)),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Operand decode for the accept cycle.
  always_comb begin
    accept   = (state_q == S_IDLE) & start_i & ~flush_i;
    s1       = rs1_i[XLEN-1] & is_signed(op_i, 1'b0);
    s2       = rs2_i[XLEN-1] & is_signed(op_i, 1'b1);
    abs1     = s1 ? -rs1_i : rs1_i;
    abs2     = s2 ? -rs2_i : rs2_i;
    div_zero = is_div(op_i) & (rs2_i == '0);
    // Signed overflow: the only quotient that does not fit in XLEN bits.
    div_ovf  = is_div(op_i) & is_signed(op_i, 1'b0) &
               (rs1_i == MIN_NEG) & (&rs2_i);
    if (div_zero) begin
      fast_res = is_rem(op_i) ? rs1_i : '1;
    end else begin
      fast_res = is_rem(op_i) ? '0 : MIN_NEG;
    end
  end

  // Sign fix-up and result selection at the end of the iterations.
  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = neg_q ? -prod : prod;
    quo_s   = neg_q ? -lo_q : lo_q;
    rem_s   = neg_q ? -hi_q : hi_q;
    if (is_div(op_q)) begin
      fix_res = is_rem(op_q) ? rem_s : quo_s;
    end else if (op_q == OP_MUL) begin
      fix_res = prod_s[XLEN-1:0];
    end else begin
      fix_res = prod_s[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_pend_d = rd_pend_q;
    neg_d     = neg_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    rd_d      = rd_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = op_i;
          rd_pend_d = rd_i;
          neg_d     = is_rem(op_i) ? s1 : (s1 ^ s2);
          cnt_d     = '0;
          if (div_zero | div_ovf) begin
            // Special cases have fixed answers; skip the iterations.
            result_d = fast_res;
            rd_d     = rd_i;
            state_d  = S_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = is_div(op_i) ? abs1 : abs2;
            opnd_d  = is_div(op_i) ? abs2 : abs1;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        rd_d     = rd_pend_q;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A killed instruction leaves the previous result visible.
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rd_d     = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_pend_q <= '0;
      neg_q     <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_pend_q <= rd_pend_d;
      neg_q     <= neg_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
    end
  end

  assign stall_o  = accept | (state_q == S_CALC) | (state_q == S_FIX);
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE) & ~flush_i;
  assign result_o = result_q;
  assign rd_o     = rd_q;
  assign state_o  = state_q;

endmodule
